// File: rtl/mac_table_maint_ctrl.sv
// Maintenance sequencer for the MAC address table: periodic aging sweeps and
// management read/delete requests, one table operation outstanding at a time.
module mac_table_maint_ctrl #(
  parameter logic [31:0] AGE_INTERVAL = 32'd156250000,
  parameter logic [15:0] MGMT_TIMEOUT = 16'd64,
  parameter logic [31:0] GC_TIMEOUT   = 32'd65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        age_enable,
  input  logic        age_now,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_del,
  input  logic [10:0] req_addr,
  input  logic [2:0]  req_way,
  output logic        req_done,
  output logic        req_err,
  output logic        tbl_gc_en,
  input  logic        tbl_gc_done,
  output logic        tbl_rd_en,
  output logic        tbl_del_en,
  output logic [10:0] tbl_addr,
  output logic [2:0]  tbl_way,
  input  logic        tbl_ack,
  output logic        gc_busy,
  output logic [15:0] sweep_count,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MGMT_WAIT = 2'd1,
    GC_WAIT   = 2'd2
  } state_t;

  localparam logic [31:0] AGE_LAST  = AGE_INTERVAL - 32'd1;
  localparam logic [31:0] MGMT_LAST = {16'd0, MGMT_TIMEOUT} - 32'd1;
  localparam logic [31:0] GC_LAST   = GC_TIMEOUT - 32'd1;

  state_t      state_reg, state_next;
  logic [31:0] timer_reg, timer_next;
  logic [31:0] wait_reg, wait_next;
  logic        gc_pending_reg, gc_pending_next;
  logic        last_was_mgmt_reg, last_was_mgmt_next;
  logic        gc_en_reg, gc_en_next;
  logic        rd_en_reg, rd_en_next;
  logic        del_en_reg, del_en_next;
  logic [10:0] addr_reg, addr_next;
  logic [2:0]  way_reg, way_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  logic        busy_reg, busy_next;
  logic [15:0] sweep_reg, sweep_next;
  logic        terr_reg, terr_next;

  logic        age_tick;
  logic        sweep_req;
  logic        pick_gc;

  always_comb begin
    timer_next = '0;
    age_tick   = 1'b0;
    if (age_enable) begin
      if (timer_reg >= AGE_LAST) begin
        age_tick = 1'b1;
      end else begin
        timer_next = timer_reg + 32'd1;
      end
    end
  end

  // Any number of sweep triggers collapse into the single pending flag.
  assign sweep_req = age_tick | age_now;
  assign pick_gc   = gc_pending_reg & (~req_valid | last_was_mgmt_reg);
  assign req_ready = rst_n & (state_reg == IDLE) & ~pick_gc;

  always_comb begin
    state_next         = state_reg;
    wait_next          = wait_reg + 32'd1;
    gc_pending_next    = gc_pending_reg | sweep_req;
    last_was_mgmt_next = last_was_mgmt_reg;
    gc_en_next         = 1'b0;
    rd_en_next         = 1'b0;
    del_en_next        = 1'b0;
    addr_next          = addr_reg;
    way_next           = way_reg;
    done_next          = 1'b0;
    err_next           = 1'b0;
    busy_next          = busy_reg;
    sweep_next         = sweep_reg;
    terr_next          = terr_reg;

    case (state_reg)
      IDLE: begin
        wait_next = '0;
        if (pick_gc) begin
          gc_en_next         = 1'b1;
          gc_pending_next    = sweep_req;
          last_was_mgmt_next = 1'b0;
          busy_next          = 1'b1;
          state_next         = GC_WAIT;
        end else if (req_valid) begin
          addr_next          = req_addr;
          way_next           = req_way;
          rd_en_next         = ~req_del;
          del_en_next        = req_del;
          last_was_mgmt_next = 1'b1;
          state_next         = MGMT_WAIT;
        end
      end
      MGMT_WAIT: begin
        // An ack in the final wait cycle still wins over the timeout.
        if (tbl_ack) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (wait_reg >= MGMT_LAST) begin
          done_next  = 1'b1;
          err_next   = 1'b1;
          terr_next  = 1'b1;
          state_next = IDLE;
        end
      end
      GC_WAIT: begin
        if (tbl_gc_done) begin
          if (sweep_reg != 16'hFFFF) begin
            sweep_next = sweep_reg + 16'd1;
          end
          busy_next  = 1'b0;
          state_next = IDLE;
        end else if (wait_reg >= GC_LAST) begin
          terr_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      timer_reg         <= '0;
      wait_reg          <= '0;
      gc_pending_reg    <= 1'b0;
      last_was_mgmt_reg <= 1'b0;
      gc_en_reg         <= 1'b0;
      rd_en_reg         <= 1'b0;
      del_en_reg        <= 1'b0;
      addr_reg          <= '0;
      way_reg           <= '0;
      done_reg          <= 1'b0;
      err_reg           <= 1'b0;
      busy_reg          <= 1'b0;
      sweep_reg         <= '0;
      terr_reg          <= 1'b0;
    end else begin
      state_reg         <= state_next;
      timer_reg         <= timer_next;
      wait_reg          <= wait_next;
      gc_pending_reg    <= gc_pending_next;
      last_was_mgmt_reg <= last_was_mgmt_next;
      gc_en_reg         <= gc_en_next;
      rd_en_reg         <= rd_en_next;
      del_en_reg        <= del_en_next;
      addr_reg          <= addr_next;
      way_reg           <= way_next;
      done_reg          <= done_next;
      err_reg           <= err_next;
      busy_reg          <= busy_next;
      sweep_reg         <= sweep_next;
      terr_reg          <= terr_next;
    end
  end

  assign tbl_gc_en   = gc_en_reg;
  assign tbl_rd_en   = rd_en_reg;
  assign tbl_del_en  = del_en_reg;
  assign tbl_addr    = addr_reg;
  assign tbl_way     = way_reg;
  assign req_done    = done_reg;
  assign req_err     = err_reg;
  assign gc_busy     = busy_reg;
  assign sweep_count = sweep_reg;
  assign timeout_err = terr_reg;

endmodule

// File: tb/tb_mac_table_maint_ctrl.sv
// Bench for mac_table_maint_ctrl: table responder model, event logs and
// per-scenario tasks compared against cycle arithmetic derived from the rules.
module tb_mac_table_maint_ctrl;

  localparam int AGE_I = 100;
  localparam int MG_I  = 64;
  localparam int GC_I  = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        age_enable = 1'b0;
  logic        age_now = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_del = 1'b0;
  logic [10:0] req_addr = '0;
  logic [2:0]  req_way = '0;
  logic        req_ready, req_done, req_err;
  logic        tbl_gc_en, tbl_gc_done, tbl_rd_en, tbl_del_en, tbl_ack;
  logic [10:0] tbl_addr;
  logic [2:0]  tbl_way;
  logic        gc_busy, timeout_err;
  logic [15:0] sweep_count;

  logic resp_ack = 1'b0, force_ack = 1'b0, resp_gc = 1'b0, force_gc = 1'b0;
  assign tbl_ack     = resp_ack | force_ack;
  assign tbl_gc_done = resp_gc | force_gc;

  mac_table_maint_ctrl #(
    .AGE_INTERVAL(32'(AGE_I)),
    .MGMT_TIMEOUT(16'(MG_I)),
    .GC_TIMEOUT  (32'(GC_I))
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .age_enable (age_enable),
    .age_now    (age_now),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_del    (req_del),
    .req_addr   (req_addr),
    .req_way    (req_way),
    .req_done   (req_done),
    .req_err    (req_err),
    .tbl_gc_en  (tbl_gc_en),
    .tbl_gc_done(tbl_gc_done),
    .tbl_rd_en  (tbl_rd_en),
    .tbl_del_en (tbl_del_en),
    .tbl_addr   (tbl_addr),
    .tbl_way    (tbl_way),
    .tbl_ack    (tbl_ack),
    .gc_busy    (gc_busy),
    .sweep_count(sweep_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; bit del; logic [10:0] addr; logic [2:0] way;} en_t;
  typedef struct {int cyc; bit err;} done_t;

  en_t   en_q[$];
  done_t done_q[$];
  int    gc_q[$];
  bit    grant_q[$];   // 1 = mgmt grant, 0 = sweep grant, in issue order

  int checks = 0, errors = 0;
  int cyc = 0, busy_cycles = 0, glitch = 0, dual_en = 0;
  int ack_delay = -1, gc_delay = 10, ack_cd = 0, gc_cd = 0;
  bit gc_auto = 1'b1, mg_active = 1'b0;
  logic [10:0] lat_addr = '0;
  logic [2:0]  lat_way = '0;

  // Observer and table model, evaluated mid-cycle.
  always @(negedge clk) begin
    en_t   e;
    done_t d;
    cyc++;
    if (gc_busy === 1'b1) busy_cycles++;
    if (tbl_rd_en === 1'b1 && tbl_del_en === 1'b1) dual_en++;
    if (mg_active && (tbl_addr !== lat_addr || tbl_way !== lat_way)) glitch++;
    if (tbl_gc_en === 1'b1) begin
      gc_q.push_back(cyc);
      grant_q.push_back(1'b0);
    end
    if (tbl_rd_en === 1'b1 || tbl_del_en === 1'b1) begin
      e.cyc = cyc; e.del = tbl_del_en; e.addr = tbl_addr; e.way = tbl_way;
      en_q.push_back(e);
      grant_q.push_back(1'b1);
      mg_active = 1'b1; lat_addr = tbl_addr; lat_way = tbl_way;
    end
    if (req_done === 1'b1) begin
      d.cyc = cyc; d.err = req_err;
      done_q.push_back(d);
      mg_active = 1'b0;
    end
    resp_ack = 1'b0;
    if (ack_cd > 0) begin
      ack_cd--;
      if (ack_cd == 0) resp_ack = 1'b1;
    end
    if ((tbl_rd_en === 1'b1 || tbl_del_en === 1'b1) && ack_delay >= 0) begin
      if (ack_delay == 0) resp_ack = 1'b1;
      else ack_cd = ack_delay;
    end
    resp_gc = 1'b0;
    if (gc_cd > 0) begin
      gc_cd--;
      if (gc_cd == 0) resp_gc = 1'b1;
    end
    if (tbl_gc_en === 1'b1 && gc_auto) begin
      if (gc_delay == 0) resp_gc = 1'b1;
      else gc_cd = gc_delay;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send_req(input bit del, input logic [10:0] a, input logic [2:0] w,
                          output int hs, output bit got);
    int n = 0;
    got = 1'b0; hs = -1;
    req_valid = 1'b1; req_del = del; req_addr = a; req_way = w;
    while (!got && n < 2000) begin
      #1;
      if (req_ready === 1'b1) begin
        got = 1'b1;
        hs = cyc;
      end
      tick(1);
      n++;
    end
    req_valid = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL req_accept: got no handshake, expected one within 2000 cycles");
    end
  endtask

  task automatic wait_done(input int base, input int lim, output bit ok);
    int n = 0;
    while (done_q.size() <= base && n < lim) begin
      tick(1);
      n++;
    end
    ok = (done_q.size() > base);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL req_done_wait: got no req_done, expected one within %0d cycles", lim);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    checks++;
    if ({req_ready, req_done, req_err, tbl_gc_en, tbl_rd_en, tbl_del_en, gc_busy, timeout_err} !== 8'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000000",
               {req_ready, req_done, req_err, tbl_gc_en, tbl_rd_en, tbl_del_en, gc_busy, timeout_err});
    end
    checks++;
    if (tbl_addr !== 11'd0 || tbl_way !== 3'd0) begin
      errors++; $display("FAIL reset_addr: got %h/%h expected 0/0", tbl_addr, tbl_way);
    end
    checks++;
    if (sweep_count !== 16'd0) begin
      errors++; $display("FAIL reset_sweep: got %0d expected 0", sweep_count);
    end
  endtask

  // Ticks occur every AGE_I enabled edges; each launches a sweep one edge later.
  task automatic test_aging();
    int r, g0;
    gc_auto = 1'b1; gc_delay = 10;
    g0 = gc_q.size();
    age_enable = 1'b1; rst_n = 1'b1; r = cyc;
    busy_cycles = 0;
    tick(330);
    checks++;
    if (gc_q.size() - g0 != 3) begin
      errors++; $display("FAIL aging_count: got %0d sweeps expected 3", gc_q.size() - g0);
    end
    for (int k = 0; k < 3; k++) begin
      if (gc_q.size() > g0 + k) begin
        checks++;
        if (gc_q[g0 + k] != r + (k + 1) * AGE_I + 1) begin
          errors++;
          $display("FAIL aging_gc_en_%0d: got cycle %0d expected %0d", k, gc_q[g0 + k] - r, (k + 1) * AGE_I + 1);
        end
      end
    end
    checks++;
    if (sweep_count !== 16'd3) begin
      errors++; $display("FAIL aging_sweep_count: got %0d expected 3", sweep_count);
    end
    checks++;
    if (busy_cycles != 33) begin
      errors++; $display("FAIL aging_busy_cycles: got %0d expected 33", busy_cycles);
    end
    age_enable = 1'b0;
  endtask

  task automatic test_read();
    int hs, b, eb;
    bit got, ok;
    ack_delay = 4; glitch = 0;
    b = done_q.size(); eb = en_q.size();
    send_req(1'b0, 11'h2A5, 3'd3, hs, got);
    if (got) begin
      wait_done(b, 100, ok);
      tick(3);
      if (ok) begin
        checks++;
        if (en_q.size() != eb + 1) begin
          errors++; $display("FAIL read_en_pulses: got %0d expected 1", en_q.size() - eb);
        end else begin
          checks++;
          if (en_q[eb].cyc != hs + 1 || en_q[eb].del !== 1'b0) begin
            errors++; $display("FAIL read_en: got cycle %0d del %0d expected cycle %0d del 0", en_q[eb].cyc, en_q[eb].del, hs + 1);
          end
          checks++;
          if (en_q[eb].addr !== 11'h2A5 || en_q[eb].way !== 3'd3) begin
            errors++; $display("FAIL read_addr: got %h/%0d expected 2a5/3", en_q[eb].addr, en_q[eb].way);
          end
          checks++;
          if (done_q[b].cyc != en_q[eb].cyc + 5 || done_q[b].err !== 1'b0) begin
            errors++; $display("FAIL read_done: got cycle %0d err %0d expected cycle %0d err 0", done_q[b].cyc, done_q[b].err, en_q[eb].cyc + 5);
          end
        end
        checks++;
        if (glitch != 0) begin
          errors++; $display("FAIL read_addr_stable: got %0d changes expected 0", glitch);
        end
      end
    end
  endtask

  task automatic test_arbitration();
    int hs, a, b, g0;
    bit got, ok;
    gc_delay = 3; ack_delay = 2;
    age_now = 1'b1; tick(1); age_now = 1'b0;
    tick(10);
    g0 = gc_q.size(); b = done_q.size();
    age_now = 1'b1; tick(1); age_now = 1'b0;
    a = cyc;
    send_req(1'b0, 11'($urandom_range(0, 2047)), 3'($urandom_range(0, 7)), hs, got);
    checks++;
    if (hs != a) begin
      errors++; $display("FAIL arb_mgmt_first: got handshake cycle %0d expected %0d", hs, a);
    end
    wait_done(b, 100, ok);
    tick(8);
    checks++;
    if (gc_q.size() != g0 + 1) begin
      errors++; $display("FAIL arb_gc_count: got %0d expected 1", gc_q.size() - g0);
    end else if (ok) begin
      checks++;
      if (gc_q[g0] != done_q[b].cyc + 1) begin
        errors++; $display("FAIL arb_gc_after_mgmt: got cycle %0d expected %0d", gc_q[g0], done_q[b].cyc + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int hs;
    bit got;
    tick(5);
    grant_q.delete();
    age_now = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_req(1'(k % 2), 11'($urandom_range(0, 2047)), 3'($urandom_range(0, 7)), hs, got);
    end
    age_now = 1'b0;
    tick(40);
    checks++;
    if (grant_q.size() != 8) begin
      errors++; $display("FAIL alt_grant_count: got %0d expected 8", grant_q.size());
    end
    for (int k = 0; k < grant_q.size() && k < 8; k++) begin
      checks++;
      if (grant_q[k] != (k % 2 == 0)) begin
        errors++; $display("FAIL alt_grant_%0d: got mgmt=%0d expected mgmt=%0d", k, grant_q[k], (k % 2 == 0));
      end
    end
  endtask

  task automatic test_merge();
    int g0;
    logic [15:0] s0;
    gc_auto = 1'b1; gc_delay = 20;
    g0 = gc_q.size(); s0 = sweep_count;
    age_now = 1'b1; tick(1); age_now = 1'b0;
    tick(4);
    checks++;
    if (gc_busy !== 1'b1) begin
      errors++; $display("FAIL merge_busy: got %b expected 1", gc_busy);
    end
    for (int k = 0; k < 3; k++) begin
      age_now = 1'b1; tick(1); age_now = 1'b0; tick(2);
    end
    tick(80);
    checks++;
    if (gc_q.size() - g0 != 2) begin
      errors++; $display("FAIL merge_sweeps: got %0d expected 2", gc_q.size() - g0);
    end
    checks++;
    if (sweep_count !== s0 + 16'd2) begin
      errors++; $display("FAIL merge_sweep_count: got %0d expected %0d", sweep_count, s0 + 16'd2);
    end
    tick(500);
    checks++;
    if (gc_q.size() - g0 != 2) begin
      errors++; $display("FAIL age_disabled: got %0d sweeps expected 2", gc_q.size() - g0);
    end
  endtask

  task automatic test_gc_timeout();
    int g0, n, f;
    logic [15:0] s0;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL terr_before: got %b expected 0", timeout_err);
    end
    gc_auto = 1'b0;
    s0 = sweep_count; g0 = gc_q.size();
    age_now = 1'b1; tick(1); age_now = 1'b0;
    n = 0;
    while (gc_busy !== 1'b1 && n < 10) begin tick(1); n++; end
    n = 0;
    while (gc_busy === 1'b1 && n < 400) begin tick(1); n++; end
    f = cyc;
    checks++;
    if (gc_q.size() != g0 + 1) begin
      errors++; $display("FAIL gc_to_count: got %0d expected 1", gc_q.size() - g0);
    end else begin
      checks++;
      if (f != gc_q[g0] + GC_I) begin
        errors++; $display("FAIL gc_to_release: got %0d cycles expected %0d", f - gc_q[g0], GC_I);
      end
    end
    checks++;
    if (timeout_err !== 1'b1 || sweep_count !== s0) begin
      errors++; $display("FAIL gc_to_state: got terr %b sweeps %0d expected 1 %0d", timeout_err, sweep_count, s0);
    end
    force_gc = 1'b1; tick(1); force_gc = 1'b0; tick(5);
    checks++;
    if (sweep_count !== s0 || gc_busy !== 1'b0) begin
      errors++; $display("FAIL gc_late_done: got sweeps %0d busy %b expected %0d 0", sweep_count, gc_busy, s0);
    end
    gc_auto = 1'b1;
  endtask

  task automatic test_mgmt_timeout();
    int hs, b, b2, eb;
    bit got, ok;
    ack_delay = -1;
    b = done_q.size(); eb = en_q.size();
    send_req(1'b1, 11'($urandom_range(0, 2047)), 3'($urandom_range(0, 7)), hs, got);
    if (got) begin
      wait_done(b, 200, ok);
      if (ok && en_q.size() > eb) begin
        checks++;
        if (done_q[b].cyc != en_q[eb].cyc + MG_I || done_q[b].err !== 1'b1) begin
          errors++; $display("FAIL mgmt_to_done: got +%0d err %0d expected +%0d err 1", done_q[b].cyc - en_q[eb].cyc, done_q[b].err, MG_I);
        end
        checks++;
        if (en_q[eb].del !== 1'b1) begin
          errors++; $display("FAIL mgmt_to_del: got del %0d expected 1", en_q[eb].del);
        end
      end
    end
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++; $display("FAIL mgmt_to_terr: got %b expected 1", timeout_err);
    end
    b2 = done_q.size();
    tick(2); force_ack = 1'b1; tick(1); force_ack = 1'b0; tick(5);
    checks++;
    if (done_q.size() != b2 || timeout_err !== 1'b1) begin
      errors++; $display("FAIL late_ack: got %0d extra done terr %b expected 0 1", done_q.size() - b2, timeout_err);
    end
  endtask

  task automatic test_random_mgmt();
    int hs, b, eb, d, exp_cyc;
    bit got, ok, del, exp_err;
    logic [10:0] a;
    logic [2:0]  w;
    for (int k = 0; k < 16; k++) begin
      case (k)
        0: d = MG_I - 1;
        1: d = MG_I;
        default: begin
          case ($urandom_range(0, 5))
            0: d = -1;
            1: d = 0;
            default: d = $urandom_range(1, 20);
          endcase
        end
      endcase
      ack_delay = d; glitch = 0;
      del = 1'($urandom_range(0, 1));
      a = 11'($urandom_range(0, 2047));
      w = 3'($urandom_range(0, 7));
      b = done_q.size(); eb = en_q.size();
      send_req(del, a, w, hs, got);
      if (!got) continue;
      wait_done(b, 200, ok);
      tick(2);
      if (!ok) continue;
      exp_err = (d < 0 || d >= MG_I);
      checks++;
      if (en_q.size() != eb + 1) begin
        errors++; $display("FAIL rnd%0d_en_pulses: got %0d expected 1", k, en_q.size() - eb);
        continue;
      end
      exp_cyc = en_q[eb].cyc + (exp_err ? MG_I : d + 1);
      checks++;
      if (en_q[eb].cyc != hs + 1 || en_q[eb].del != del || en_q[eb].addr !== a || en_q[eb].way !== w) begin
        errors++;
        $display("FAIL rnd%0d_issue: got cyc %0d del %0d %h/%0d expected cyc %0d del %0d %h/%0d",
                 k, en_q[eb].cyc, en_q[eb].del, en_q[eb].addr, en_q[eb].way, hs + 1, del, a, w);
      end
      checks++;
      if (done_q[b].cyc != exp_cyc || done_q[b].err != exp_err) begin
        errors++;
        $display("FAIL rnd%0d_done (delay %0d): got cyc %0d err %0d expected cyc %0d err %0d",
                 k, d, done_q[b].cyc, done_q[b].err, exp_cyc, exp_err);
      end
      checks++;
      if (glitch != 0 || dual_en != 0) begin
        errors++; $display("FAIL rnd%0d_tbl_stable: got %0d addr changes %0d dual enables expected 0 0", k, glitch, dual_en);
      end
    end
  endtask

  task automatic test_reset_mid_gc();
    int b, g0;
    gc_auto = 1'b1; gc_delay = 30;
    b = done_q.size();
    age_now = 1'b1; tick(1); age_now = 1'b0;
    tick(6);
    g0 = gc_q.size();
    checks++;
    if (gc_busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_busy: got %b expected 1", gc_busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, req_done, req_err, tbl_gc_en, tbl_rd_en, tbl_del_en, gc_busy, timeout_err} !== 8'b0) begin
      errors++;
      $display("FAIL rstmid_flags: got %b expected 00000000",
               {req_ready, req_done, req_err, tbl_gc_en, tbl_rd_en, tbl_del_en, gc_busy, timeout_err});
    end
    checks++;
    if (sweep_count !== 16'd0 || tbl_addr !== 11'd0 || tbl_way !== 3'd0) begin
      errors++; $display("FAIL rstmid_regs: got sweeps %0d %h/%0d expected 0 0/0", sweep_count, tbl_addr, tbl_way);
    end
    tick(2);
    rst_n = 1'b1;
    tick(3);
    force_gc = 1'b1; tick(1); force_gc = 1'b0;
    tick(40);
    checks++;
    if (sweep_count !== 16'd0 || gc_busy !== 1'b0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_after: got sweeps %0d busy %b terr %b expected 0 0 0", sweep_count, gc_busy, timeout_err);
    end
    checks++;
    if (done_q.size() != b || gc_q.size() != g0) begin
      errors++; $display("FAIL rstmid_events: got %0d done %0d gc_en expected 0 0", done_q.size() - b, gc_q.size() - g0);
    end
  endtask

  initial begin
    test_reset();
    test_aging();
    test_read();
    test_arbitration();
    test_back_to_back();
    test_merge();
    test_gc_timeout();
    test_mgmt_timeout();
    test_random_mgmt();
    test_reset_mid_gc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
